// File: rtl/vga_board_scanner.sv
// VGA raster scanner drawing a BOARD_N x BOARD_N cell board from a synchronous cell RAM.
// One pixel tick of latency on sync/de/rgb; free-running raster, no backpressure.
module vga_board_scanner #(
    parameter int   CLK_DIV   = 2,
    parameter int   H_ACTIVE  = 640,
    parameter int   H_FP      = 16,
    parameter int   H_SYNC    = 96,
    parameter int   H_BP      = 48,
    parameter int   V_ACTIVE  = 480,
    parameter int   V_FP      = 10,
    parameter int   V_SYNC    = 2,
    parameter int   V_BP      = 33,
    parameter logic SYNC_POL  = 1'b0,
    parameter int   BOARD_N   = 14,
    parameter int   CELL_LOG2 = 5,
    parameter int   GRID_W    = 2,
    parameter int   ORG_X     = 95,
    parameter int   ORG_Y     = 15
) (
    input  logic                               clk,
    input  logic                               rst_n,
    output logic [$clog2(BOARD_N*BOARD_N)-1:0] vram_addr,
    input  logic [5:0]                         vram_q,
    output logic                               hsync,
    output logic                               vsync,
    output logic                               de,
    output logic [11:0]                        rgb_out,
    output logic                               frame_start
);
    localparam int H_TOTAL   = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL   = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW        = $clog2(H_TOTAL);
    localparam int VW        = $clog2(V_TOTAL);
    localparam int DW        = $clog2(CLK_DIV);
    localparam int AW        = $clog2(BOARD_N * BOARD_N);
    localparam int PITCH     = 1 << CELL_LOG2;
    localparam int BOARD_PX  = BOARD_N * PITCH;
    localparam int BOARD_END = BOARD_PX + GRID_W;

    logic [DW-1:0] div_q, div_d;
    logic [HW-1:0] hcount_q, hcount_d;
    logic [VW-1:0] vcount_q, vcount_d;
    logic          hsync_q, vsync_q, de_q, frame_start_q;
    logic [11:0]   rgb_q, rgb_d;
    logic          pix_en, h_wrap, v_wrap;
    logic [31:0]   hx, vy, dx, dy, col_raw, row_raw, col, row;
    logic          active, in_board, grid, hs_act, vs_act;
    logic          unused_vram_bits;

    assign unused_vram_bits = ^{vram_q[4:3], vram_q[1:0]};

    assign pix_en   = (div_q == DW'(CLK_DIV - 1));
    assign div_d    = pix_en ? '0 : div_q + 1'b1;

    assign hx       = 32'(hcount_q);
    assign vy       = 32'(vcount_q);
    assign h_wrap   = (hx == H_TOTAL - 1);
    assign v_wrap   = (vy == V_TOTAL - 1);
    assign hcount_d = h_wrap ? '0 : hcount_q + 1'b1;
    assign vcount_d = !h_wrap ? vcount_q : (v_wrap ? '0 : vcount_q + 1'b1);

    assign active   = (hx < H_ACTIVE) && (vy < V_ACTIVE);
    assign hs_act   = (hx >= H_ACTIVE + H_FP) && (hx < H_ACTIVE + H_FP + H_SYNC);
    assign vs_act   = (vy >= V_ACTIVE + V_FP) && (vy < V_ACTIVE + V_FP + V_SYNC);

    // Offsets wrap to huge values left/above the origin; only used once in_board holds.
    assign dx       = hx - 32'(ORG_X);
    assign dy       = vy - 32'(ORG_Y);
    assign in_board = active && (hx >= ORG_X) && (hx < ORG_X + BOARD_END)
                             && (vy >= ORG_Y) && (vy < ORG_Y + BOARD_END);
    assign col_raw  = dx >> CELL_LOG2;
    assign row_raw  = dy >> CELL_LOG2;
    assign col      = (col_raw > BOARD_N - 1) ? 32'(BOARD_N - 1) : col_raw;
    assign row      = (row_raw > BOARD_N - 1) ? 32'(BOARD_N - 1) : row_raw;
    assign grid     = ((dx & 32'(PITCH - 1)) < GRID_W) || ((dy & 32'(PITCH - 1)) < GRID_W)
                   || (dx >= BOARD_PX) || (dy >= BOARD_PX);

    // Counters only move on pix_en, so the address is stable for the whole tick and
    // the RAM answer is back before the next tick registers this pixel's colour.
    assign vram_addr = in_board ? AW'(row * BOARD_N + col) : '0;

    always_comb begin
        rgb_d = 12'h000;
        if (!active)        rgb_d = 12'h000;
        else if (!in_board) rgb_d = 12'heee;
        else if (grid)      rgb_d = 12'hccc;
        else if (vram_q[5]) rgb_d = 12'hf70;
        else if (vram_q[2]) rgb_d = 12'h70f;
        else                rgb_d = 12'hddd;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q         <= '0;
            hcount_q      <= '0;
            vcount_q      <= '0;
            hsync_q       <= ~SYNC_POL;
            vsync_q       <= ~SYNC_POL;
            de_q          <= 1'b0;
            rgb_q         <= 12'h000;
            frame_start_q <= 1'b0;
        end else begin
            div_q         <= div_d;
            frame_start_q <= pix_en && (hx == 0) && (vy == 0);
            if (pix_en) begin
                hcount_q <= hcount_d;
                vcount_q <= vcount_d;
                hsync_q  <= hs_act ? SYNC_POL : ~SYNC_POL;
                vsync_q  <= vs_act ? SYNC_POL : ~SYNC_POL;
                de_q     <= active;
                rgb_q    <= rgb_d;
            end
        end
    end

    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign de          = de_q;
    assign rgb_out     = rgb_q;
    assign frame_start = frame_start_q;
endmodule

// File: tb/tb_vga_board_scanner.sv
// Bench for vga_board_scanner: a small-raster instance probed pixel by pixel and a
// second active-high-sync, CLK_DIV=4 instance checked for timing and address range.
module tb_vga_board_scanner;
    localparam int A_DIV = 2, A_HA = 80, A_HF = 2, A_HS = 6, A_HB = 2;
    localparam int A_VA = 72, A_VF = 1, A_VS = 2, A_VB = 2;
    localparam int A_HT = A_HA + A_HF + A_HS + A_HB;
    localparam int A_VT = A_VA + A_VF + A_VS + A_VB;
    localparam int A_FRAME = A_HT * A_VT;
    localparam int B_DIV = 4, B_HA = 72, B_HF = 2, B_HS = 4, B_HB = 2;
    localparam int B_VA = 68, B_VF = 1, B_VS = 2, B_VB = 1;
    localparam int B_HT = B_HA + B_HF + B_HS + B_HB;
    localparam int B_VT = B_VA + B_VF + B_VS + B_VB;
    localparam int B_FRAME = B_HT * B_VT;

    typedef struct {
        int         x;
        int         y;
        logic [11:0] rgb;
        logic [2:0]  sig;   // {hsync, vsync, de}
        logic [3:0]  addr;
    } probe_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_a_n, rst_b_n;
    logic [3:0]  addr_a;
    logic [5:0]  vq_a;
    logic        hs_a, vs_a, de_a, fs_a;
    logic [11:0] rgb_a;
    logic [5:0]  addr_b;
    logic [5:0]  vq_b;
    logic        hs_b, vs_b, de_b, fs_b;
    logic [11:0] rgb_b;
    logic [5:0]  mem_a [16];

    int checks = 0;
    int errors = 0;
    probe_t tbl [16];
    probe_t sbq [$];

    vga_board_scanner #(
        .CLK_DIV(A_DIV), .H_ACTIVE(A_HA), .H_FP(A_HF), .H_SYNC(A_HS), .H_BP(A_HB),
        .V_ACTIVE(A_VA), .V_FP(A_VF), .V_SYNC(A_VS), .V_BP(A_VB), .SYNC_POL(1'b0),
        .BOARD_N(4), .CELL_LOG2(4), .GRID_W(2), .ORG_X(10), .ORG_Y(5)
    ) dut_a (
        .clk(clk), .rst_n(rst_a_n), .vram_addr(addr_a), .vram_q(vq_a),
        .hsync(hs_a), .vsync(vs_a), .de(de_a), .rgb_out(rgb_a), .frame_start(fs_a)
    );

    vga_board_scanner #(
        .CLK_DIV(B_DIV), .H_ACTIVE(B_HA), .H_FP(B_HF), .H_SYNC(B_HS), .H_BP(B_HB),
        .V_ACTIVE(B_VA), .V_FP(B_VF), .V_SYNC(B_VS), .V_BP(B_VB), .SYNC_POL(1'b1),
        .BOARD_N(8), .CELL_LOG2(3), .GRID_W(2), .ORG_X(0), .ORG_Y(0)
    ) dut_b (
        .clk(clk), .rst_n(rst_b_n), .vram_addr(addr_b), .vram_q(vq_b),
        .hsync(hs_b), .vsync(vs_b), .de(de_b), .rgb_out(rgb_b), .frame_start(fs_b)
    );

    always @(posedge clk) vq_a <= mem_a[addr_a];
    always @(posedge clk) vq_b <= addr_b;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    task automatic run_a();
        int hs_cnt = 0, vs_cnt = 0, de_cnt = 0, fs_ticks = 0, fs_clks = 0;
        int fs_idx0 = -1, fs_idx1 = -1, glitch = 0, n = 0, fs_clk = -1, fs2_cnt = 0, fs2_last = -1;
        logic [3:0] tick_addr, prev_addr;
        logic [11:0] rgb0;
        logic de0;
        probe_t p;

        rst_a_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("a_reset_sync_de_fs", {hs_a, vs_a, de_a, fs_a}, 4'b1100);
        check("a_reset_rgb", rgb_a, 12'h000);
        check("a_reset_addr", addr_a, 4'd0);
        foreach (tbl[i]) sbq.push_back(tbl[i]);
        @(negedge clk);
        rst_a_n = 1'b1;
        tick_addr = addr_a;
        for (int k = 0; k <= A_FRAME + 20 * A_HT + 30; k++) begin
            prev_addr = tick_addr;
            for (int c = 0; c < A_DIV; c++) begin
                @(posedge clk);
                #1;
                if (fs_a) fs_clks++;
                if (c < A_DIV - 1 && addr_a !== tick_addr) glitch++;
            end
            tick_addr = addr_a;
            if (fs_a) begin
                if (fs_ticks == 0) fs_idx0 = k;
                else if (fs_ticks == 1) fs_idx1 = k;
                fs_ticks++;
            end
            if (k < A_FRAME) begin
                if (hs_a == 1'b0) hs_cnt++;
                if (vs_a == 1'b0) vs_cnt++;
                if (de_a == 1'b1) de_cnt++;
            end
            if (sbq.size() > 0 && sbq[0].y * A_HT + sbq[0].x == k) begin
                p = sbq.pop_front();
                check($sformatf("a_rgb(%0d,%0d)", p.x, p.y), rgb_a, p.rgb);
                check($sformatf("a_sync_de(%0d,%0d)", p.x, p.y), {hs_a, vs_a, de_a}, p.sig);
                check($sformatf("a_addr(%0d,%0d)", p.x, p.y), prev_addr, p.addr);
            end
        end
        check("a_probes_consumed", sbq.size(), 0);
        check("a_hsync_ticks", hs_cnt, A_HS * A_VT);
        check("a_vsync_ticks", vs_cnt, A_VS * A_HT);
        check("a_de_ticks", de_cnt, A_HA * A_VA);
        check("a_fs_ticks", fs_ticks, 2);
        check("a_fs_clks", fs_clks, 2);
        check("a_fs_first_idx", fs_idx0, 0);
        check("a_fs_period", fs_idx1, A_FRAME);
        check("a_addr_stable", glitch, 0);

        // Now showing pixel (30,20) of the second frame: plain cell, row 0 col 1.
        check("a_pre_reset_rgb", rgb_a, 12'hddd);
        #2 rst_a_n = 1'b0;
        #1;
        check("a_midreset_sync_de_fs", {hs_a, vs_a, de_a, fs_a}, 4'b1100);
        check("a_midreset_rgb", rgb_a, 12'h000);
        check("a_midreset_addr", addr_a, 4'd0);
        repeat (2) @(negedge clk);
        rst_a_n = 1'b1;
        for (int k = 0; k <= A_FRAME; k++) begin
            for (int c = 0; c < A_DIV; c++) begin
                @(posedge clk);
                #1;
                n++;
                if (fs_a && fs_clk < 0) fs_clk = n;
            end
            if (k == 0) begin
                rgb0 = rgb_a;
                de0  = de_a;
            end
            if (fs_a) begin
                fs2_cnt++;
                fs2_last = k;
            end
        end
        check("a_restart_first_fs_clk", fs_clk, A_DIV);
        check("a_restart_pix0", {de0, rgb0}, {1'b1, 12'heee});
        check("a_restart_fs_count", fs2_cnt, 2);
        check("a_restart_fs_period", fs2_last, A_FRAME);
    endtask

    task automatic run_b();
        int hs_cnt = 0, vs_cnt = 0, de_cnt = 0, n = 0, fs_clk = -1, off_edge = 0;
        int max_addr = 0;
        logic [14:0] prev_out;

        rst_b_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("b_reset_sync_de_fs", {hs_b, vs_b, de_b, fs_b}, 4'b0000);
        check("b_reset_rgb", rgb_b, 12'h000);
        check("b_reset_addr", addr_b, 6'd0);
        prev_out = {hs_b, vs_b, de_b, rgb_b};
        @(negedge clk);
        rst_b_n = 1'b1;
        for (int k = 0; k < B_FRAME; k++) begin
            for (int c = 0; c < B_DIV; c++) begin
                @(posedge clk);
                #1;
                n++;
                if (fs_b && fs_clk < 0) fs_clk = n;
                if (int'(addr_b) > max_addr) max_addr = int'(addr_b);
                if (c < B_DIV - 1 && {hs_b, vs_b, de_b, rgb_b} !== prev_out) off_edge++;
            end
            prev_out = {hs_b, vs_b, de_b, rgb_b};
            if (hs_b == 1'b1) hs_cnt++;
            if (vs_b == 1'b1) vs_cnt++;
            if (de_b == 1'b1) de_cnt++;
        end
        check("b_first_fs_clk", fs_clk, B_DIV);
        check("b_outputs_only_on_tick", off_edge, 0);
        check("b_hsync_high_ticks", hs_cnt, B_HS * B_VT);
        check("b_vsync_high_ticks", vs_cnt, B_VS * B_HT);
        check("b_de_ticks", de_cnt, B_HA * B_VA);
        check("b_max_addr", max_addr, 63);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem_a[i] = 6'b011011;
        mem_a[5]  = 6'b100100;
        mem_a[6]  = 6'b000100;
        mem_a[9]  = 6'b000000;
        mem_a[10] = 6'b100000;

        tbl[0]  = '{1,  0,  12'heee, 3'b111, 4'd0};
        tbl[1]  = '{81, 3,  12'h000, 3'b110, 4'd0};
        tbl[2]  = '{85, 10, 12'h000, 3'b010, 4'd0};
        tbl[3]  = '{30, 25, 12'hf70, 3'b111, 4'd5};
        tbl[4]  = '{50, 25, 12'h70f, 3'b111, 4'd6};
        tbl[5]  = '{9,  30, 12'heee, 3'b111, 4'd0};
        tbl[6]  = '{10, 30, 12'hccc, 3'b111, 4'd4};
        tbl[7]  = '{26, 30, 12'hccc, 3'b111, 4'd5};
        tbl[8]  = '{75, 30, 12'hccc, 3'b111, 4'd7};
        tbl[9]  = '{76, 30, 12'heee, 3'b111, 4'd0};
        tbl[10] = '{45, 40, 12'hf70, 3'b111, 4'd10};
        tbl[11] = '{30, 45, 12'hddd, 3'b111, 4'd9};
        tbl[12] = '{63, 60, 12'hddd, 3'b111, 4'd15};
        tbl[13] = '{74, 70, 12'hccc, 3'b111, 4'd15};
        tbl[14] = '{30, 71, 12'heee, 3'b111, 4'd0};
        tbl[15] = '{20, 74, 12'h000, 3'b100, 4'd0};

        fork
            run_a();
            run_b();
        join
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, time=%0t", $time);
        $fatal(1, "watchdog expired");
    end
endmodule
